// File: rtl/branch_pc_unit.sv
// branch_pc_unit: execute-stage branch resolution and fetch-PC owner.
// Decodes funct3 against the comparator flags, computes branch/jump targets,
// holds the fetch PC, raises a multi-cycle flush after each redirect and
// traps (freezing the PC) on a misaligned target.
// Optional feature: define BRANCH_STATS_EN to enable the br_count/taken_count
// counters; otherwise both outputs are tied to zero.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        valid_in,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        beq,
    input  logic        blt,
    output logic        u,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        cond;
    logic        taken;
    logic        acc;
    logic        aligned;
    logic        trap_hit;
    logic [31:0] target;

    // Branch condition decode; 010/011 are never taken
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:         cond = beq;
            3'b001:         cond = ~beq;
            3'b100, 3'b110: cond = blt;
            3'b101, 3'b111: cond = ~blt;
            default:        cond = 1'b0;
        endcase
    end

    // Target selection with jalr > jal > branch precedence
    always_comb begin
        target = ex_pc + imm;
        if (is_jalr) begin
            target = (rs1 + imm) & ~32'h1;
        end
    end

    assign u        = funct3[1];
    assign pc_plus4 = ex_pc + 32'd4;
    assign taken    = is_jal | is_jalr | (is_branch & cond);
    assign acc      = valid_in & ~stall & (state == RUN);
    assign aligned  = (target[1:0] == 2'b00);
    assign redirect = acc & taken & aligned;
    assign trap_hit = acc & taken & ~aligned;

    // PC / flush / trap state machine; stall freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            cnt      <= '0;
            flush    <= 1'b0;
            misalign <= 1'b0;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    if (trap_hit) begin
                        state    <= TRAP;
                        misalign <= 1'b1;
                    end else if (redirect) begin
                        pc    <= target;
                        state <= FLUSH;
                        cnt   <= 3'(FLUSH_CYCLES);
                        flush <= 1'b1;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
                FLUSH: begin
                    pc <= pc + 32'd4;
                    if (cnt == 3'd1) begin
                        state <= RUN;
                        cnt   <= '0;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                TRAP: begin
                    flush <= 1'b0;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_q;
    logic [31:0] tk_q;

    // Conditional-branch statistics; jumps are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
            tk_q <= '0;
        end else begin
            if (acc & is_branch) begin
                br_q <= br_q + 32'd1;
            end
            if (acc & is_branch & taken & aligned) begin
                tk_q <= tk_q + 32'd1;
            end
        end
    end

    assign br_count    = br_q;
    assign taken_count = tk_q;
`else
    assign br_count    = '0;
    assign taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: scoreboard bench for branch_pc_unit (RESET_PC=0x100,
// FLUSH_CYCLES=2). A reference model pushes expected post-edge state when
// stimulus is driven; the record is popped and compared after the edge.
module tb_branch_pc_unit;

    localparam logic [31:0] RPC = 32'h100;
    localparam int unsigned FC  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        valid_in;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        beq;
    logic        blt;
    logic        u;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        flush;
    logic        misalign;
    logic [31:0] br_count;
    logic [31:0] taken_count;

    branch_pc_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .ex_pc(ex_pc), .imm(imm), .rs1(rs1),
        .beq(beq), .blt(blt), .u(u), .pc(pc), .pc_plus4(pc_plus4),
        .redirect(redirect), .flush(flush), .misalign(misalign),
        .br_count(br_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] brc;
        logic [31:0] tkc;
    } exp_t;

    exp_t sb[$];

    // reference model state: 0 run, 1 flush, 2 trap
    logic [31:0] m_pc;
    logic [31:0] m_br;
    logic [31:0] m_tk;
    logic        m_flush;
    logic        m_mis;
    int          m_st;
    int unsigned m_cnt;

    function automatic logic ref_taken(input logic br, input logic jal, input logic jalr,
                                       input logic [2:0] f3, input logic eq, input logic lt);
        if (jal || jalr) return 1'b1;
        if (!br) return 1'b0;
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4: return lt;
            3'd5: return !lt;
            3'd6: return lt;
            3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [31:0] epc, input logic [31:0] im,
                        input logic [31:0] r1, input logic eq, input logic lt, input logic st);
        logic [31:0] tgt;
        logic        tk;
        logic        acc;
        logic        ok;
        exp_t        e;
        exp_t        got;
        valid_in = v; is_branch = br; is_jal = jal; is_jalr = jalr;
        funct3 = f3; ex_pc = epc; imm = im; rs1 = r1; beq = eq; blt = lt; stall = st;
        #2;
        tk  = ref_taken(br, jal, jalr, f3, eq, lt);
        tgt = jalr ? ((r1 + im) & 32'hFFFF_FFFE) : (epc + im);
        acc = v && !st && (m_st == 0);
        ok  = (tgt[1:0] == 2'b00);
        check_eq("u", 32'(u), 32'(f3[1]));
        check_eq("pc_plus4", pc_plus4, epc + 32'd4);
        check_eq("redirect", 32'(redirect), 32'(acc && tk && ok));
        if (!st) begin
            if (acc && br) begin
                m_br = m_br + 1;
                if (tk && ok) m_tk = m_tk + 1;
            end
            case (m_st)
                0: begin
                    if (acc && tk) begin
                        if (!ok) begin
                            m_st  = 2;
                            m_mis = 1'b1;
                        end else begin
                            m_pc    = tgt;
                            m_st    = 1;
                            m_cnt   = FC;
                            m_flush = 1'b1;
                        end
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                end
                1: begin
                    m_pc = m_pc + 32'd4;
                    if (m_cnt == 1) begin
                        m_st    = 0;
                        m_flush = 1'b0;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
                default: ;
            endcase
        end
        e.pc = m_pc; e.flush = m_flush; e.mis = m_mis;
`ifdef BRANCH_STATS_EN
        e.brc = m_br; e.tkc = m_tk;
`else
        e.brc = 32'h0; e.tkc = 32'h0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_eq("pc", pc, got.pc);
        check_eq("flush", 32'(flush), 32'(got.flush));
        check_eq("misalign", 32'(misalign), 32'(got.mis));
        check_eq("br_count", br_count, got.brc);
        check_eq("taken_count", taken_count, got.tkc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic branch(input logic [2:0] f3, input logic [31:0] epc, input logic [31:0] im,
                          input logic eq, input logic lt);
        step(1, 1, 0, 0, f3, epc, im, 32'h0, eq, lt, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_pc = RPC; m_br = '0; m_tk = '0; m_flush = 1'b0; m_mis = 1'b0; m_st = 0; m_cnt = 0;
        sb.delete();
        check_eq("rst_pc", pc, RPC);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_misalign", 32'(misalign), 32'h0);
        check_eq("rst_br_count", br_count, 32'h0);
        check_eq("rst_taken_count", taken_count, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        stall = 0; valid_in = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
        funct3 = '0; ex_pc = '0; imm = '0; rs1 = '0; beq = 0; blt = 0;
        rst_n = 1'b0;
        #10;
        do_reset();

        idle(3);
        check_eq("idle_pc", pc, 32'h10C);

        // BEQ taken, then taken branches offered during flush are ignored
        branch(3'b000, 32'h200, 32'h40, 1, 0);
        check_eq("beq_target", pc, 32'h240);
        branch(3'b000, 32'h500, 32'h40, 1, 0);
        branch(3'b000, 32'h500, 32'h40, 1, 0);
        check_eq("beq_flush_end_pc", pc, 32'h248);

        // BLTU taken (negative offset), BGE/010/011/BLT not taken, BNE/BGEU taken
        branch(3'b110, 32'h400, 32'hFFFF_FFF8, 0, 1);
        check_eq("bltu_target", pc, 32'h3F8);
        idle(2);
        branch(3'b101, 32'h600, 32'h20, 0, 1);
        branch(3'b010, 32'h600, 32'h20, 1, 1);
        branch(3'b011, 32'h600, 32'h20, 1, 1);
        branch(3'b100, 32'h600, 32'h20, 1, 0);
        branch(3'b001, 32'h600, 32'h10, 0, 0);
        idle(2);
        branch(3'b111, 32'h700, 32'h100, 0, 0);
        idle(2);

        // JALR clears bit 0
        step(1, 0, 0, 1, 3'd0, 32'h900, 32'h10, 32'h1001, 0, 0, 0);
        check_eq("jalr_target", pc, 32'h1010);
        idle(2);

        // precedence: jalr > jal > branch
        step(1, 1, 1, 1, 3'b001, 32'hA00, 32'h20, 32'h2000, 1, 0, 0);
        idle(2);
        step(1, 1, 1, 0, 3'b000, 32'hB00, 32'h8, 32'h0, 0, 0, 0);
        idle(2);

        // stall in RUN suppresses a taken branch
        step(1, 1, 0, 0, 3'b000, 32'hC00, 32'h40, 32'h0, 1, 0, 1);

        // stall during the 2nd flush cycle for 3 cycles
        branch(3'b000, 32'hC00, 32'h40, 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 3'b000, 32'hD00, 32'h40, 32'h0, 1, 0, 1);
        check_eq("stall_flush_held", 32'(flush), 32'h1);
        idle(1);
        check_eq("stall_flush_done", 32'(flush), 32'h0);

        // PC wrap 0xFFFF_FFFC -> 0
        step(1, 0, 1, 0, 3'd0, 32'h0, 32'hFFFF_FFF4, 32'h0, 0, 0, 0);
        idle(2);
        check_eq("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        idle(1);
        check_eq("wrap_pc", pc, 32'h0);

        // reset mid-flush
        branch(3'b000, 32'h200, 32'h40, 1, 0);
        do_reset();
        idle(1);

        // statistics: 5 branches, 2 taken, 1 JAL
        do_reset();
        branch(3'b000, 32'h200, 32'h40, 1, 0);
        idle(2);
        branch(3'b001, 32'h200, 32'h40, 1, 0);
        branch(3'b100, 32'h200, 32'h40, 0, 0);
        branch(3'b010, 32'h200, 32'h40, 1, 1);
        branch(3'b101, 32'h300, 32'h20, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 3'd0, 32'h400, 32'h10, 32'h0, 0, 0, 0);
        idle(2);
`ifdef BRANCH_STATS_EN
        check_eq("stats_br", br_count, 32'd5);
        check_eq("stats_taken", taken_count, 32'd2);
`else
        check_eq("stats_br_off", br_count, 32'd0);
        check_eq("stats_taken_off", taken_count, 32'd0);
`endif

        // misaligned JAL traps; pc frozen until reset
        step(1, 0, 1, 0, 3'd0, 32'h300, 32'h2, 32'h0, 0, 0, 0);
        check_eq("trap_misalign", 32'(misalign), 32'h1);
        for (int i = 0; i < 3; i++) branch(3'b000, 32'h200, 32'h40, 1, 0);
        check_eq("trap_flush", 32'(flush), 32'h0);
        do_reset();
        idle(1);
        check_eq("recover_pc", pc, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
